baud_gen_frac: RTL

- Runtime-programmable UART baud generator with a fractional divisor. Produces an oversample tick, a mid-bit sample strobe and a bit-period tick.
- Supersedes the fixed-M generator. The divisor can be reloaded safely while running, and the phase can be realigned to an RX start edge.
- Feeds uart_rx (uses s_tick and mid_tick) and uart_tx (uses s_tick and bit_tick).

---
 rtl/baud_gen_frac.sv | 110 +++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional-divisor UART baud generator: oversample, mid-bit and bit ticks.
// Divisor reloads are shadowed and take effect only on a period boundary.
module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int DEFAULT_DIV  = 651,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic              s_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OW-1:0] MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] LAST = OW'(OVS - 1);

  logic [DIV_W-1:0]  cnt;
  logic [OW-1:0]     ovs_cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [DIV_W-1:0]  div_act;
  logic [FRAC_W-1:0] frac_act;
  logic [DIV_W-1:0]  sh_div;
  logic [FRAC_W-1:0] sh_frac;
  logic              pending;

  logic [DIV_W:0]    lim;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;
  logic              load_ok;
  logic              apply;

  assign lim     = {1'b0, div_act} + {{DIV_W{1'b0}}, extra};
  assign acc_sum = {1'b0, acc} + {1'b0, frac_act};
  assign wrap    = ({1'b0, cnt} == lim - (DIV_W + 1)'(1));
  assign load_ok = cfg_load && (cfg_div >= DIV_W'(2));

  // sync_clr suppresses the tick, which also blocks a pending apply
  assign s_tick   = en && !sync_clr && wrap;
  assign mid_tick = s_tick && (ovs_cnt == MID);
  assign bit_tick = s_tick && (ovs_cnt == LAST);
  assign apply    = pending && (s_tick || !en);
  assign cfg_busy = pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      ovs_cnt  <= '0;
      acc      <= '0;
      extra    <= 1'b0;
      div_act  <= DIV_W'(DEFAULT_DIV);
      frac_act <= FRAC_W'(DEFAULT_FRAC);
      sh_div   <= '0;
      sh_frac  <= '0;
      pending  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_load) begin
        if (load_ok) begin
          sh_div  <= cfg_div;
          sh_frac <= cfg_frac;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (load_ok) pending <= 1'b1;
      else if (apply) pending <= 1'b0;

      if (apply) begin
        div_act  <= sh_div;
        frac_act <= sh_frac;
      end

      if (!en) begin
        cnt     <= '0;
        ovs_cnt <= '0;
        acc     <= '0;
        extra   <= 1'b0;
      end else if (sync_clr) begin
        cnt     <= '0;
        ovs_cnt <= '0;
      end else if (s_tick) begin
        cnt     <= '0;
        ovs_cnt <= (ovs_cnt == LAST) ? '0 : ovs_cnt + OW'(1);
        if (apply) begin
          acc   <= '0;
          extra <= 1'b0;
        end else begin
          {extra, acc} <= acc_sum;
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule
